rom_dl_sequencer: RTL and testbench

- Sits between the HPS download stream (ioctl_*) and the game core's ROM write port (dn_*).
- Accepts bytes only while the ROM index (0) is downloading and decodes each address into a ROM region.
- Stretches every write to WR_CYCLES, applying ioctl_wait backpressure while a write is in progress.
- Holds the game in reset during a download and for HOLD_CYCLES afterwards, and reports load status and size errors.

---
 rtl/rom_dl_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// ROM download sequencer: bridges the HPS ioctl byte stream to the core's ROM write port.
// Decodes each byte into a region, stretches each write, backpressures the HPS while a
// write is in flight, holds the core in reset around a download and reports load status.
module rom_dl_sequencer #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [13:0] PROG_SIZE   = 14'h1000,
  parameter logic [13:0] GFX_SIZE    = 14'h0400,
  parameter int unsigned WR_CYCLES   = 2,
  parameter logic [15:0] HOLD_CYCLES = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [13:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [1:0]  dn_region,
  output logic        game_reset,
  output logic        rom_loaded,
  output logic        dl_error,
  output logic [14:0] byte_count
);

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StCheck} state_e;

  localparam logic [14:0] TotalSize = {1'b0, PROG_SIZE} + {1'b0, GFX_SIZE};
  localparam logic [3:0]  WrCycles  = 4'(WR_CYCLES);
  localparam logic [1:0]  RegProg   = 2'd0;
  localparam logic [1:0]  RegGfx    = 2'd1;
  localparam logic [1:0]  RegOvf    = 2'd2;

  state_e      state_q, state_d;
  logic        wait_q, wait_d;
  logic [13:0] dn_addr_q, dn_addr_d;
  logic [7:0]  dn_data_q, dn_data_d;
  logic        dn_wr_q, dn_wr_d;
  logic [1:0]  dn_region_q, dn_region_d;
  logic        game_reset_q, game_reset_d;
  logic        rom_loaded_q, rom_loaded_d;
  logic        dl_error_q, dl_error_d;
  logic [14:0] byte_count_q, byte_count_d;
  logic [15:0] hold_q, hold_d;
  logic [3:0]  wcnt_q, wcnt_d;
  // Download ended while a write was still in flight.
  logic        end_q, end_d;

  logic        index_hit;
  logic        active;
  logic        rom_wr;
  logic [1:0]  region;
  logic [14:0] addr_lo;
  logic [14:0] byte_inc;

  assign index_hit = (ioctl_index == ROM_INDEX);
  assign active    = ioctl_download && index_hit;
  assign rom_wr    = ioctl_wr && index_hit;
  assign addr_lo   = {1'b0, ioctl_addr[13:0]};
  assign byte_inc  = (byte_count_q == 15'h7FFF) ? byte_count_q : byte_count_q + 15'd1;

  // Region decode of the incoming byte address; any high address bit means overflow.
  always_comb begin
    region = RegOvf;
    if (ioctl_addr[24:14] == 11'd0) begin
      if (addr_lo < {1'b0, PROG_SIZE}) begin
        region = RegProg;
      end else if (addr_lo < TotalSize) begin
        region = RegGfx;
      end
    end
  end

  // Next-state logic for the sequencer and all registered outputs.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_wr_d      = 1'b0;
    dn_region_d  = dn_region_q;
    game_reset_d = game_reset_q;
    rom_loaded_d = rom_loaded_q;
    dl_error_d   = dl_error_q;
    byte_count_d = byte_count_q;
    hold_d       = hold_q;
    wcnt_d       = wcnt_q;
    end_d        = end_q;

    unique case (state_q)
      StIdle: begin
        if (active) begin
          state_d      = StAccept;
          byte_count_d = 15'd0;
          dl_error_d   = 1'b0;
          rom_loaded_d = 1'b0;
          game_reset_d = 1'b1;
        end else if (hold_q != 16'd0) begin
          hold_d       = hold_q - 16'd1;
          game_reset_d = (hold_q != 16'd1);
        end else begin
          game_reset_d = 1'b0;
        end
      end

      StAccept: begin
        // A strobe coinciding with the download ending is still taken.
        if (rom_wr) begin
          dn_addr_d    = ioctl_addr[13:0];
          dn_data_d    = ioctl_dout;
          dn_region_d  = region;
          wait_d       = 1'b1;
          wcnt_d       = 4'd0;
          byte_count_d = byte_inc;
          end_d        = !active;
          state_d      = StWrite;
        end else if (!active) begin
          state_d = StCheck;
        end
      end

      StWrite: begin
        // HPS ignored ioctl_wait: drop the byte and flag it.
        if (rom_wr) begin
          dl_error_d = 1'b1;
        end
        if (!active) begin
          end_d = 1'b1;
        end
        if (wcnt_q != WrCycles) begin
          wcnt_d = wcnt_q + 4'd1;
          if (dn_region_q == RegOvf) begin
            dl_error_d = 1'b1;
          end else begin
            dn_wr_d = 1'b1;
          end
        end else begin
          wait_d  = 1'b0;
          state_d = (end_q || !active) ? StCheck : StAccept;
        end
      end

      StCheck: begin
        rom_loaded_d = (byte_count_q == TotalSize) && !dl_error_q;
        if (byte_count_q < TotalSize) begin
          dl_error_d = 1'b1;
        end
        hold_d       = HOLD_CYCLES;
        game_reset_d = 1'b1;
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset holds the core in reset for HOLD_CYCLES.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wait_q       <= 1'b0;
      dn_addr_q    <= 14'd0;
      dn_data_q    <= 8'd0;
      dn_wr_q      <= 1'b0;
      dn_region_q  <= RegProg;
      game_reset_q <= 1'b1;
      rom_loaded_q <= 1'b0;
      dl_error_q   <= 1'b0;
      byte_count_q <= 15'd0;
      hold_q       <= HOLD_CYCLES;
      wcnt_q       <= 4'd0;
      end_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      dn_region_q  <= dn_region_d;
      game_reset_q <= game_reset_d;
      rom_loaded_q <= rom_loaded_d;
      dl_error_q   <= dl_error_d;
      byte_count_q <= byte_count_d;
      hold_q       <= hold_d;
      wcnt_q       <= wcnt_d;
      end_q        <= end_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign dn_region  = dn_region_q;
  assign game_reset = game_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign dl_error   = dl_error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Directed bench for rom_dl_sequencer: region-decode vector table plus hand-written
// sequences for full/short/overflow loads, backpressure violation, foreign index and reset.
module tb_rom_dl_sequencer;

  logic        clk_sys;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [13:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;
  logic        game_reset;
  logic        rom_loaded;
  logic        dl_error;
  logic [14:0] byte_count;

  int total;
  int bad;

  rom_dl_sequencer dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_region      (dn_region),
    .game_reset     (game_reset),
    .rom_loaded     (rom_loaded),
    .dl_error       (dl_error),
    .byte_count     (byte_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  region;
    logic [2:0]  pat;     // dn_wr seen in cycles N+3,N+2,N+1 after the strobe
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One byte with 4-cycle spacing; observes the write pulse and the wait window.
  task automatic xfer(input logic [24:0] a, input logic [7:0] d, output logic [2:0] pat,
                      output logic [1:0] reg_seen, output logic stable, output logic wait_ok);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    pat      = 3'b000;
    stable   = 1'b1;
    wait_ok  = 1'b1;
    reg_seen = dn_region;
    for (int i = 0; i < 3; i++) begin
      pat[i] = dn_wr;
      if (!ioctl_wait) wait_ok = 1'b0;
      if (dn_wr && (dn_addr != a[13:0] || dn_data != d)) stable = 1'b0;
      tick();
    end
    if (ioctl_wait || dn_wr) wait_ok = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " wait"},   ioctl_wait, 0);
    check({tag, " dn_wr"},  dn_wr, 0);
    check({tag, " addr"},   dn_addr, 0);
    check({tag, " data"},   dn_data, 0);
    check({tag, " region"}, dn_region, 0);
    check({tag, " greset"}, game_reset, 1);
    check({tag, " loaded"}, rom_loaded, 0);
    check({tag, " error"},  dl_error, 0);
    check({tag, " count"},  byte_count, 0);
  endtask

  initial begin
    logic [2:0]  pat;
    logic [1:0]  rg;
    logic        st;
    logic        wok;
    int          n_ok;
    int          n_badreg;
    int          n_bad;
    int          k;
    int          nwr;
    logic        seen;
    logic [24:0] a;

    total = 0;
    bad   = 0;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;

    vecs[0] = '{25'h0000000, 8'hA5, 2'd0, 3'b110};
    vecs[1] = '{25'h0000FFF, 8'h3C, 2'd0, 3'b110};
    vecs[2] = '{25'h0001000, 8'h5A, 2'd1, 3'b110};
    vecs[3] = '{25'h00013FF, 8'hC3, 2'd1, 3'b110};
    vecs[4] = '{25'h0001400, 8'h11, 2'd2, 3'b000};
    vecs[5] = '{25'h0003FFF, 8'h22, 2'd2, 3'b000};
    vecs[6] = '{25'h0004000, 8'h33, 2'd2, 3'b000};
    vecs[7] = '{25'h1000010, 8'h44, 2'd2, 3'b000};
    vecs[8] = '{25'h0000123, 8'h77, 2'd0, 3'b110};

    #22;
    check_reset_vals("por");
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();

    // Region decode table, started during the post-reset hold.
    start_dl(8'd0);
    for (int i = 0; i < 9; i++) begin
      xfer(vecs[i].addr, vecs[i].data, pat, rg, st, wok);
      check($sformatf("vec%0d region", i), rg, vecs[i].region);
      check($sformatf("vec%0d pulse", i), pat, vecs[i].pat);
      check($sformatf("vec%0d stable", i), st, 1);
      check($sformatf("vec%0d wait", i), wok, 1);
      check($sformatf("vec%0d count", i), byte_count, i + 1);
    end
    check("tbl greset", game_reset, 1);
    end_dl();
    check("tbl count", byte_count, 9);
    check("tbl error", dl_error, 1);
    check("tbl loaded", rom_loaded, 0);

    // Full load of 0x1400 bytes.
    start_dl(8'd0);
    check("full clr err", dl_error, 0);
    check("full clr cnt", byte_count, 0);
    n_ok = 0; n_badreg = 0; n_bad = 0;
    for (int i = 0; i < 'h1400; i++) begin
      a = 25'(i);
      xfer(a, a[7:0], pat, rg, st, wok);
      if (pat == 3'b110) n_ok++;
      if (rg != ((i < 'h1000) ? 2'd0 : 2'd1)) n_badreg++;
      if (!st || !wok) n_bad++;
    end
    check("full pulses", n_ok, 'h1400);
    check("full regions", n_badreg, 0);
    check("full stable", n_bad, 0);
    check("full greset", game_reset, 1);
    end_dl();
    check("full loaded", rom_loaded, 1);
    check("full error", dl_error, 0);
    check("full count", byte_count, 15'h1400);
    k = 0;
    while (game_reset && k < 2000) begin
      tick();
      k++;
    end
    check("full hold", k, 1024);

    // Foreign index download is ignored.
    start_dl(8'd254);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ioctl_addr = 25'(i);
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (ioctl_wait || dn_wr) seen = 1'b1;
        tick();
      end
    end
    ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    check("idx activity", seen, 0);
    check("idx loaded", rom_loaded, 1);
    check("idx error", dl_error, 0);
    check("idx count", byte_count, 15'h1400);
    check("idx greset", game_reset, 0);
    ioctl_index = 8'd0;

    // Short load.
    start_dl(8'd0);
    check("short greset", game_reset, 1);
    check("short clr ld", rom_loaded, 0);
    for (int i = 0; i < 'h800; i++) begin
      a = 25'(i);
      xfer(a, a[7:0], pat, rg, st, wok);
    end
    end_dl();
    check("short error", dl_error, 1);
    check("short loaded", rom_loaded, 0);
    check("short count", byte_count, 15'h0800);

    // Overflow by one byte.
    start_dl(8'd0);
    for (int i = 0; i < 'h1400; i++) begin
      a = 25'(i);
      xfer(a, a[7:0], pat, rg, st, wok);
    end
    check("ovf pre err", dl_error, 0);
    xfer(25'h1400, 8'h00, pat, rg, st, wok);
    check("ovf pulse", pat, 3'b000);
    check("ovf region", rg, 2);
    check("ovf wait", wok, 1);
    check("ovf err", dl_error, 1);
    end_dl();
    check("ovf count", byte_count, 15'h1401);
    check("ovf loaded", rom_loaded, 0);
    check("ovf error", dl_error, 1);

    // Strobe while ioctl_wait is high is dropped.
    start_dl(8'd0);
    ioctl_addr = 25'h5;
    ioctl_dout = 8'h55;
    ioctl_wr   = 1'b1;
    tick();
    check("viol wait", ioctl_wait, 1);
    ioctl_addr = 25'h6;
    ioctl_dout = 8'h66;
    tick();
    ioctl_wr = 1'b0;
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      if (dn_wr) nwr++;
      tick();
    end
    check("viol writes", nwr, 2);
    check("viol count", byte_count, 1);
    check("viol error", dl_error, 1);
    check("viol addr", dn_addr, 14'h5);

    // Reset during the second cycle of a write pulse.
    ioctl_addr = 25'h7;
    ioctl_dout = 8'h77;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("mid wr1", dn_wr, 1);
    tick();
    check("mid wr2", dn_wr, 1);
    #2;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check_reset_vals("mid");
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    k = 0;
    while (game_reset && k < 2000) begin
      tick();
      k++;
    end
    check("mid hold", k, 1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
